// File: rtl/spi_arbiter.sv
// Shares one spi_ctrl engine between two requesters. Each requester owns the bus for a
// whole transaction. The divider/latency config is applied before the first byte when it changes.
module spi_arbiter #(
    parameter logic [1:0] DEFAULT_DIVIDER = 2'd1,
    parameter logic       DEFAULT_LATENCY = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req0_valid_i,
    input  logic [7:0] req0_data_i,
    input  logic       req0_dc_i,
    input  logic       req0_last_i,
    input  logic [1:0] req0_divider_i,
    input  logic       req0_latency_i,
    output logic       req0_ready_o,
    output logic       req0_rvalid_o,
    input  logic       req1_valid_i,
    input  logic [7:0] req1_data_i,
    input  logic       req1_dc_i,
    input  logic       req1_last_i,
    input  logic [1:0] req1_divider_i,
    input  logic       req1_latency_i,
    output logic       req1_ready_o,
    output logic       req1_rvalid_o,
    output logic [7:0] rdata_o,
    output logic [1:0] grant_o,
    output logic       spi_start_o,
    output logic [7:0] spi_data_in_o,
    output logic       spi_dc_o,
    output logic       spi_end_txn_o,
    output logic       spi_set_config_o,
    output logic [1:0] spi_divider_o,
    output logic       spi_read_latency_o,
    input  logic [7:0] spi_data_out_i,
    input  logic       spi_busy_i
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CONFIG = 3'd1;
    localparam logic [2:0] S_SEND   = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_OWN    = 3'd5;

    logic [2:0] state_q, state_d;
    logic [1:0] grant_q, grant_d;
    logic       rr_q, rr_d;
    logic       cfg_valid_q, cfg_valid_d;
    logic       last_q, last_d;
    logic [1:0] div_q, div_d;
    logic       lat_q, lat_d;
    logic [7:0] rdata_q, rdata_d;
    logic [1:0] rvalid_q, rvalid_d;

    logic       owner;
    logic       own_valid;
    logic [7:0] own_data;
    logic       own_dc;
    logic       own_last;
    logic       sel;
    logic [1:0] sel_div;
    logic       sel_lat;
    logic       send;

    assign owner     = grant_q[1];
    assign own_valid = owner ? req1_valid_i : req0_valid_i;
    assign own_data  = owner ? req1_data_i  : req0_data_i;
    assign own_dc    = owner ? req1_dc_i    : req0_dc_i;
    assign own_last  = owner ? req1_last_i  : req0_last_i;

    // On contention the round-robin pointer picks; otherwise whoever is valid.
    assign sel     = (req0_valid_i && req1_valid_i) ? rr_q : req1_valid_i;
    assign sel_div = sel ? req1_divider_i : req0_divider_i;
    assign sel_lat = sel ? req1_latency_i : req0_latency_i;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        cfg_valid_d = cfg_valid_q;
        last_d      = last_q;
        div_d       = div_q;
        lat_d       = lat_q;
        rdata_d     = rdata_q;
        rvalid_d    = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (req0_valid_i || req1_valid_i) begin
                    grant_d = sel ? 2'b10 : 2'b01;
                    if (!cfg_valid_q || sel_div != div_q || sel_lat != lat_q) begin
                        div_d   = sel_div;
                        lat_d   = sel_lat;
                        state_d = S_CONFIG;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end
            S_CONFIG: begin
                cfg_valid_d = 1'b1;
                state_d     = own_valid ? S_SEND : S_OWN;
            end
            S_SEND: begin
                last_d  = own_last;
                state_d = S_HOLD;
            end
            S_HOLD: state_d = S_WAIT;
            S_WAIT: begin
                if (!spi_busy_i) begin
                    rdata_d  = spi_data_out_i;
                    rvalid_d = grant_q;
                    if (last_q) begin
                        grant_d = 2'b00;
                        rr_d    = ~owner;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_OWN;
                    end
                end
            end
            S_OWN: begin
                if (own_valid) state_d = S_SEND;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            grant_q     <= 2'b00;
            rr_q        <= 1'b0;
            cfg_valid_q <= 1'b0;
            last_q      <= 1'b0;
            div_q       <= DEFAULT_DIVIDER;
            lat_q       <= DEFAULT_LATENCY;
            rdata_q     <= 8'h00;
            rvalid_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            cfg_valid_q <= cfg_valid_d;
            last_q      <= last_d;
            div_q       <= div_d;
            lat_q       <= lat_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

    // Byte fields pass straight through from the owner only while SEND is active.
    assign send               = (state_q == S_SEND);
    assign spi_start_o        = send;
    assign spi_data_in_o      = send ? own_data : 8'h00;
    assign spi_dc_o           = send & own_dc;
    assign spi_end_txn_o      = send & own_last;
    assign spi_set_config_o   = (state_q == S_CONFIG);
    assign spi_divider_o      = div_q;
    assign spi_read_latency_o = lat_q;
    assign req0_ready_o       = send & grant_q[0];
    assign req1_ready_o       = send & grant_q[1];
    assign req0_rvalid_o      = rvalid_q[0];
    assign req1_rvalid_o      = rvalid_q[1];
    assign rdata_o            = rdata_q;
    assign grant_o            = grant_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Bench for spi_arbiter: directed scenarios plus randomized two-requester traffic.
// A transaction-level model predicts byte order, ownership, config pulses and read data.
module tb_spi_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic       dc;
        logic       last;
        logic [1:0] div;
        logic       lat;
        logic       first;
    } txn_t;

    typedef struct {
        int         owner;
        logic [7:0] data;
        int         cyc;
    } rsp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_dc, req0_last, req0_latency, req0_ready, req0_rvalid;
    logic [7:0] req0_data;
    logic [1:0] req0_divider;
    logic       req1_valid, req1_dc, req1_last, req1_latency, req1_ready, req1_rvalid;
    logic [7:0] req1_data;
    logic [1:0] req1_divider;
    logic [7:0] rdata;
    logic [1:0] grant;
    logic       spi_start, spi_dc, spi_end_txn, spi_set_config, spi_read_latency;
    logic [7:0] spi_data_in;
    logic [1:0] spi_divider;
    logic [7:0] spi_data_out = 8'h00;
    logic       spi_busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    txn_t exp_q[2][$];
    rsp_t rsp_q[$];
    int   grant_log[$];
    int   t_valid[2];
    int   first_start[2];
    int   cfg_total = 0;
    int   rvalid_total = 0;
    int   busy_fixed = -1;
    logic [2:0] cnt = 3'd0;
    logic [2:0] last_k = 3'd0;

    // model state
    logic       m_cfg_valid = 1'b0;
    logic [1:0] m_div = 2'd1;
    logic       m_lat = 1'b0;
    int         m_rr = 0;
    int         m_owner = 0;
    logic       m_open = 1'b0;
    int         cfg_cnt = 0;
    logic [1:0] prev_grant = 2'b00;
    logic       prev_v0 = 1'b0;
    logic       prev_v1 = 1'b0;

    spi_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(req0_valid), .req0_data_i(req0_data), .req0_dc_i(req0_dc),
        .req0_last_i(req0_last), .req0_divider_i(req0_divider), .req0_latency_i(req0_latency),
        .req0_ready_o(req0_ready), .req0_rvalid_o(req0_rvalid),
        .req1_valid_i(req1_valid), .req1_data_i(req1_data), .req1_dc_i(req1_dc),
        .req1_last_i(req1_last), .req1_divider_i(req1_divider), .req1_latency_i(req1_latency),
        .req1_ready_o(req1_ready), .req1_rvalid_o(req1_rvalid),
        .rdata_o(rdata), .grant_o(grant),
        .spi_start_o(spi_start), .spi_data_in_o(spi_data_in), .spi_dc_o(spi_dc),
        .spi_end_txn_o(spi_end_txn), .spi_set_config_o(spi_set_config),
        .spi_divider_o(spi_divider), .spi_read_latency_o(spi_read_latency),
        .spi_data_out_i(spi_data_out), .spi_busy_i(spi_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] resp_of(input logic [7:0] x);
        return {x[3:0], x[7:4]} ^ 8'h3C;
    endfunction

    function automatic logic [1:0] onehot(input int r);
        return (r != 0) ? 2'b10 : 2'b01;
    endfunction

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail_event(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got an event, required none", name);
    endfunction

    function automatic logic [15:0] log_bits();
        logic [15:0] v = 16'h0000;
        foreach (grant_log[i]) v = {v[13:0], onehot(grant_log[i])};
        return v;
    endfunction

    // spi_ctrl stand-in: busy for k cycles after each start, answers with resp_of(byte)
    assign spi_busy = (cnt != 3'd0);
    initial begin : engine
        int k;
        forever begin
            @(posedge clk);
            if (rst) begin
                cnt <= 3'd0;
            end else if (spi_start) begin
                k = (busy_fixed >= 0) ? busy_fixed : int'($urandom_range(0, 4));
                cnt          <= 3'(k);
                last_k       <= 3'(k);
                spi_data_out <= resp_of(spi_data_in);
            end else if (cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    initial begin : monitor
        txn_t t;
        rsp_t e;
        int   w;
        int   exp_c;
        logic need;
        forever begin
            @(negedge clk);
            if (rst) begin
                rsp_q.delete();
                exp_q[0].delete();
                exp_q[1].delete();
                m_cfg_valid = 1'b0;
                m_rr = 0;
                m_open = 1'b0;
                cfg_cnt = 0;
            end else begin
                if (grant != 2'b00 && prev_grant == 2'b00) begin
                    w = (prev_v0 && prev_v1) ? m_rr : (prev_v1 ? 1 : 0);
                    check("arb_winner", grant, onehot(w));
                    grant_log.push_back(w);
                    m_owner = w;
                end
                if (spi_set_config) begin
                    cfg_cnt++;
                    cfg_total++;
                end
                if (spi_start || req0_ready || req1_ready)
                    check("ready_pulse", {req1_ready, req0_ready}, spi_start ? onehot(m_owner) : 2'b00);
                if (spi_start) begin
                    check("start_owner", grant, onehot(m_owner));
                    if (exp_q[m_owner].size() == 0) begin
                        fail_event("unexpected_start");
                    end else begin
                        t = exp_q[m_owner].pop_front();
                        check("spi_data_in", spi_data_in, t.data);
                        check("spi_dc_end_txn", {spi_dc, spi_end_txn}, {t.dc, t.last});
                        check("txn_continuity", m_open, !t.first);
                        if (t.first) begin
                            need = !m_cfg_valid || t.div != m_div || t.lat != m_lat;
                            check("config_pulses", cfg_cnt, need);
                            check("config_value", {spi_divider, spi_read_latency}, {t.div, t.lat});
                            m_cfg_valid = 1'b1;
                            m_div = t.div;
                            m_lat = t.lat;
                            first_start[m_owner] = cyc;
                        end else begin
                            check("config_pulses_mid", cfg_cnt, 0);
                        end
                        m_open = !t.last;
                        if (t.last) m_rr = 1 - m_owner;
                        e.owner = m_owner;
                        e.data = resp_of(t.data);
                        e.cyc = cyc;
                        rsp_q.push_back(e);
                    end
                    cfg_cnt = 0;
                end
                if (req0_rvalid || req1_rvalid) begin
                    rvalid_total++;
                    if (rsp_q.size() == 0) begin
                        fail_event("unexpected_rvalid");
                    end else begin
                        e = rsp_q.pop_front();
                        check("rvalid_owner", {req1_rvalid, req0_rvalid}, onehot(e.owner));
                        check("rdata", rdata, e.data);
                        exp_c = e.cyc + ((int'(last_k) + 1 > 2) ? int'(last_k) + 1 : 2) + 1;
                        check("rvalid_cycle", cyc, exp_c);
                    end
                end
            end
            prev_grant = grant;
            prev_v0 = req0_valid;
            prev_v1 = req1_valid;
        end
    end

    task automatic drive(input int r, input logic v, input txn_t t);
        if (r == 0) begin
            req0_valid = v; req0_data = t.data; req0_dc = t.dc; req0_last = t.last;
            req0_divider = t.div; req0_latency = t.lat;
        end else begin
            req1_valid = v; req1_data = t.data; req1_dc = t.dc; req1_last = t.last;
            req1_divider = t.div; req1_latency = t.lat;
        end
    endtask

    // Entered just after a rising edge; returns just after the edge that ends the last ready.
    task automatic send_txn(input int r, input int nbytes, input logic [1:0] div, input logic lat,
                            input int gap, input int fixed_data);
        txn_t t;
        int   n;
        for (int b = 0; b < nbytes; b++) begin
            if (b > 0) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    check("gap_grant", grant, onehot(r));
                    @(posedge clk); #1;
                end
            end
            t.data  = (fixed_data >= 0) ? 8'(fixed_data) : 8'($urandom);
            t.dc    = 1'($urandom);
            t.last  = (b == nbytes - 1);
            t.div   = div;
            t.lat   = lat;
            t.first = (b == 0);
            exp_q[r].push_back(t);
            drive(r, 1'b1, t);
            if (b == 0) t_valid[r] = cyc;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!((r == 0) ? req0_ready : req1_ready) && n < 300);
            if (n >= 300) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: got no ready for requester %0d, required one within 300 cycles", r);
                @(posedge clk); #1;
                drive(r, 1'b0, t);
                return;
            end
            @(posedge clk); #1;
            drive(r, 1'b0, t);
        end
    endtask

    task automatic rand_agent(input int r);
        int ntx = $urandom_range(1, 3);
        logic [1:0] div;
        for (int i = 0; i < ntx; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            div = ($urandom_range(0, 1) != 0) ? 2'd1 : 2'd3;
            send_txn(r, $urandom_range(1, 4), div, (div == 2'd3), $urandom_range(0, 2), -1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || grant != 2'b00 || exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got outstanding work after 500 cycles, required none");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    task automatic check_reset(input string name);
        check(name, {grant, req0_ready, req1_ready, req0_rvalid, req1_rvalid, rdata,
                     spi_start, spi_set_config, spi_end_txn, spi_dc, spi_data_in,
                     spi_divider, spi_read_latency},
              {2'b00, 4'b0000, 8'h00, 4'b0000, 8'h00, 2'd1, 1'b0});
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of run, required finish before 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        txn_t idle_t;
        int   c0;
        int   r0;
        idle_t = '0;
        rst = 1'b1;
        drive(0, 1'b0, idle_t);
        drive(1, 1'b0, idle_t);
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check_reset("reset_state");
        @(posedge clk); #1;
        rst = 1'b0;

        // single byte 0xA5 right after reset: CONFIG then SEND
        busy_fixed = 3;
        c0 = cfg_total;
        send_txn(0, 1, 2'd1, 1'b0, 0, 8'hA5);
        drain();
        check("t1_start_latency", first_start[0] - t_valid[0], 2);
        check("t1_config_count", cfg_total - c0, 1);
        check("t1_rdata", rdata, 8'h66);
        check("t1_grant_idle", grant, 2'b00);

        // same config again: no CONFIG, one-cycle latency
        c0 = cfg_total;
        send_txn(0, 1, 2'd1, 1'b0, 0, -1);
        drain();
        check("t2_start_latency", first_start[0] - t_valid[0], 1);
        check("t2_config_count", cfg_total - c0, 0);

        // contention after reset: 0, 1, then 0 again, then 1
        busy_fixed = -1;
        do_reset();
        grant_log.delete();
        c0 = cfg_total;
        fork
            send_txn(0, 3, 2'd1, 1'b0, 0, -1);
            send_txn(1, 3, 2'd3, 1'b1, 0, -1);
        join
        fork
            send_txn(0, 1, 2'd1, 1'b0, 0, -1);
            send_txn(1, 1, 2'd3, 1'b1, 0, -1);
        join
        drain();
        check("t3_grant_order", log_bits(), 16'b0110_0110);
        check("t3_config_count", cfg_total - c0, 4);

        // owner idles 10 cycles between bytes while req1 waits
        grant_log.delete();
        fork
            send_txn(0, 3, 2'd1, 1'b0, 10, -1);
            begin
                repeat (2) begin @(posedge clk); #1; end
                send_txn(1, 1, 2'd3, 1'b1, 0, -1);
            end
        join
        drain();
        check("t4_grant_order", log_bits(), 16'b0110);

        // reset while waiting on a busy engine
        busy_fixed = 6;
        send_txn(0, 1, 2'd2, 1'b1, 0, -1);
        @(posedge clk); #1;
        rst = 1'b1;
        r0 = rvalid_total;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset("reset_in_wait");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        check("t5_no_rvalid", rvalid_total - r0, 0);
        busy_fixed = -1;
        c0 = cfg_total;
        send_txn(0, 1, 2'd2, 1'b1, 0, -1);
        drain();
        check("t5_config_after_reset", cfg_total - c0, 1);
        check("t5_start_latency", first_start[0] - t_valid[0], 2);

        // randomized traffic from both requesters
        for (int it = 0; it < 25; it++) begin
            fork
                rand_agent(0);
                rand_agent(1);
            join
            drain();
        end
        check("final_queues_empty", rsp_q.size() + exp_q[0].size() + exp_q[1].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Shares the single `spi_ctrl` peripheral SPI engine between two requesters. Requester 0 is the CPU-side MMIO path; requester 1 is a hardware display-refresh or streaming engine. Each requester owns the SPI bus for a whole multi-byte transaction, from the first byte to the byte flagged `last`. The arbiter applies that requester's divider and read-latency configuration before the first byte, and returns each received byte with a one-cycle valid pulse.

## Interface
Parameters:
- `DEFAULT_DIVIDER`, 2'd1: value driven on `spi_divider` after reset.
- `DEFAULT_LATENCY`, 1'b0: value driven on `spi_read_latency` after reset.

Ports (`N` = 0 or 1 for per-requester ports):
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `reqN_valid`  in  1  requester has a byte to send; held until `reqN_ready`.
- `reqN_data`  in  8  byte to transmit.
- `reqN_dc`  in  1  data/command flag for this byte.
- `reqN_last`  in  1  this byte ends the transaction; CS deasserts after it.
- `reqN_divider`  in  2  clock divider for the transaction; sampled at grant.
- `reqN_latency`  in  1  read latency for the transaction; sampled at grant.
- `reqN_ready`  out  1  one-cycle pulse; byte accepted.
- `reqN_rvalid`  out  1  one-cycle pulse; `rdata` holds the byte received for this requester.
- `rdata`  out  8  last byte captured from `spi_data_out`, shared by both requesters.
- `grant`  out  2  one-hot current owner; 2'b00 when idle.
- `spi_start`, `spi_data_in[7:0]`, `spi_dc`, `spi_end_txn`  out  control to `spi_ctrl`.
- `spi_set_config`, `spi_divider[1:0]`, `spi_read_latency`  out  configuration to `spi_ctrl`.
- `spi_data_out`  in  8  received byte from `spi_ctrl`.
- `spi_busy`  in  1  `spi_ctrl` busy.

## Operation
State machine: IDLE, CONFIG, SEND, HOLD, WAIT, OWN.
- **IDLE**
  - Select the owner from the valid requesters. If both are valid, the requester pointed to by the round-robin pointer `rr` wins.
  - Latch the owner's divider and latency, then set `grant`.
  - Go to CONFIG if the latched config differs from the applied config, or if `cfg_valid` is 0. Otherwise go to SEND.
- **CONFIG**
  - One cycle: `spi_set_config`=1, with `spi_divider` and `spi_read_latency` set to the latched values.
  - Set `cfg_valid`, then go to SEND.
- **SEND**
  - Entered only when the owner's valid is high.
  - `spi_start`=1. `spi_data_in`, `spi_dc` and `spi_end_txn` are driven combinationally from the owner's data, dc and last.
  - `reqN_ready` pulses for the owner; the arbiter records `last`. Go to HOLD.
- **HOLD**
  - One cycle; `spi_busy` is ignored. Go to WAIT.
- **WAIT**
  - Stay while `spi_busy`=1.
  - When `spi_busy`=0: `rdata` <= `spi_data_out` and `reqN_rvalid` pulses next cycle for the owner.
  - If the recorded last=1: clear `grant`, set `rr` to the other requester, go to IDLE.
  - Otherwise go to OWN.
- **OWN**
  - Bus stays locked to the owner. Go to SEND when the owner's valid=1.
  - The other requester's valid is ignored; there is no timeout.
- Config is never rechecked mid-transaction.
- `spi_divider` and `spi_read_latency` hold their last value outside CONFIG.

## Timing
- Reset (synchronous, `rst`=1 at a clock edge):
  - state=IDLE, `rr`=0, `cfg_valid`=0.
  - `grant`=0, `reqN_ready`=0, `reqN_rvalid`=0, `rdata`=0.
  - `spi_start`=0, `spi_set_config`=0, `spi_end_txn`=0, `spi_dc`=0, `spi_data_in`=0.
  - `spi_divider`=`DEFAULT_DIVIDER`, `spi_read_latency`=`DEFAULT_LATENCY`.
- Reset mid-transaction: abandon immediately with no `rvalid`. The first transaction after reset always issues CONFIG.
- Valid-to-start latency from IDLE: 1 cycle with matching config, 2 cycles with CONFIG.
- From OWN: `spi_start` rises the cycle after `reqN_valid` is seen high.
- `spi_busy` fall to `reqN_rvalid`: 1 cycle.
- End of transaction to next grant: IDLE takes 1 cycle, so there is at least 1 idle cycle between transactions.
- Pulses: `spi_start`, `spi_set_config`, `reqN_ready` and `reqN_rvalid` are each exactly 1 cycle. They are never asserted for both requesters at once.
- Requester rules:
  - Valid that drops before ready: no byte is sent, and the grant is kept if the transaction is already open.
  - A requester losing arbitration keeps valid high and is served next by round robin.

## Test plan
- Reset, then req0 sends 1 byte 0xA5 (last=1, div=1, lat=0):
  - CONFIG pulse once with div=1.
  - `spi_start` 2 cycles after valid, with data 0xA5 and `spi_end_txn`=1.
  - `rdata`=`spi_data_out` model value, with `req0_rvalid` 1 cycle after busy falls.
  - `grant` returns to 0.
- req0 then sends a second transaction with identical config: no `spi_set_config`, and `spi_start` 1 cycle after valid.
- Both valid in the same IDLE cycle after reset:
  - req0 is granted first (3-byte transaction); req1 is starved during it and `req1_ready` never pulses.
  - req1 is granted next. If both then request again, req0 goes next.
- req1 uses a different config (div=3, lat=1): `spi_set_config` pulses with div=3 and lat=1 before its first byte only, not for bytes 2 and 3.
- Owner drops valid between bytes for 10 cycles while req1 is valid: arbiter stays in OWN, `grant`=owner, and there is no req1 activity until the owner's last byte completes.
- Assert `rst` during WAIT:
  - Next cycle all outputs are at reset values and no `rvalid` is issued.
  - The next transaction issues CONFIG.
